vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 118 +++++++++++
 tb/tb_vga_sync_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator with pixel-clock divider.
// Produces the current pixel coordinate (x, y) for external colour generators.
// It registers the returned colour, blanked outside the visible area, together
// with active-low hsync/vsync. The sync and colour outputs therefore reach the
// pins one pixel after the coordinate is presented.
// Ports:
//   clk, rst                 - system clock, synchronous active-high reset
//   x, y                     - current pixel column/row (registered)
//   red, green, blue         - colour from generators for current x, y
//   vga_red/green/blue       - registered colour to DAC
//   hsync, vsync             - registered active-low sync
//   pix_tick                 - one-clk pulse on each pixel advance (decode)
//   frame_end                - one-clk pulse on last pixel of frame (decode)
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] x,
  output logic [10:0] y,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic [3:0]  vga_red,
  output logic [3:0]  vga_green,
  output logic [3:0]  vga_blue,
  output logic        hsync,
  output logic        vsync,
  output logic        pix_tick,
  output logic        frame_end
);

  localparam int unsigned CW       = 11;
  localparam int unsigned DIV_W    = 4;
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [DIV_W-1:0] r_div;
  logic [CW-1:0]    r_x;
  logic [CW-1:0]    r_y;
  logic [3:0]       r_red;
  logic [3:0]       r_green;
  logic [3:0]       r_blue;
  logic             r_hsync;
  logic             r_vsync;

  logic w_div_last;
  logic w_pix_tick;
  logic w_x_last;
  logic w_y_last;
  logic w_blank;
  logic w_hs_raw;
  logic w_vs_raw;

  // Tick is a decode of the divider, gated by rst so it stays low in reset
  // (with CLK_DIV = 1 the divider sits at its last value permanently).
  assign w_div_last = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_pix_tick = w_div_last & ~rst;
  assign w_x_last   = (r_x == CW'(H_TOTAL - 1));
  assign w_y_last   = (r_y == CW'(V_TOTAL - 1));

  // Blank and raw sync are derived from the coordinate currently presented.
  assign w_blank  = (r_x >= CW'(H_VISIBLE)) | (r_y >= CW'(V_VISIBLE));
  assign w_hs_raw = ~((r_x >= CW'(HS_START)) & (r_x < CW'(HS_END)));
  assign w_vs_raw = ~((r_y >= CW'(VS_START)) & (r_y < CW'(VS_END)));

  // Divider, raster counters and pin registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_div <= w_div_last ? '0 : r_div + DIV_W'(1);
      if (w_pix_tick) begin
        if (w_x_last) begin
          r_x <= '0;
          r_y <= w_y_last ? '0 : r_y + CW'(1);
        end else begin
          r_x <= r_x + CW'(1);
        end
        r_red   <= w_blank ? 4'h0 : red;
        r_green <= w_blank ? 4'h0 : green;
        r_blue  <= w_blank ? 4'h0 : blue;
        r_hsync <= w_hs_raw;
        r_vsync <= w_vs_raw;
      end
    end
  end

  assign x         = r_x;
  assign y         = r_y;
  assign vga_red   = r_red;
  assign vga_green = r_green;
  assign vga_blue  = r_blue;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign pix_tick  = w_pix_tick;
  assign frame_end = w_pix_tick & w_x_last & w_y_last;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using a reduced raster so that many frames fit in a short run.
// u_dut (CLK_DIV=2) is checked through a scoreboard of expected pin values.
// u_dut1 (CLK_DIV=1) is checked against a direct per-clock expectation.
module tb_vga_sync_gen;

  localparam int D  = 2;
  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam logic [13:0] PINS_RST = 14'b0000_0000_0000_11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [10:0] x, y, x1, y1;
  logic [3:0]  red, green, blue;
  logic [3:0]  vr, vg, vb, vr1, vg1, vb1;
  logic        hs, vs, tick, fe, hs1, vs1, tick1, fe1;
  logic [3:0]  kr, kg, kb;

  vga_sync_gen #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) u_dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .red(red), .green(green), .blue(blue),
    .vga_red(vr), .vga_green(vg), .vga_blue(vb), .hsync(hs), .vsync(vs),
    .pix_tick(tick), .frame_end(fe)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) u_dut1 (
    .clk(clk), .rst(rst), .x(x1), .y(y1), .red(4'hF), .green(4'h8), .blue(4'h1),
    .vga_red(vr1), .vga_green(vg1), .vga_blue(vb1), .hsync(hs1), .vsync(vs1),
    .pix_tick(tick1), .frame_end(fe1)
  );

  // Colour generator: pure function of a coordinate, keyed per run segment.
  function automatic logic [11:0] colour(input int xx, input int yy);
    logic [3:0] r, g, b;
    r = 4'(xx) ^ kr;
    g = 4'(yy) ^ kg;
    b = 4'(xx + yy) ^ kb;
    return {r, g, b};
  endfunction

  always_comb {red, green, blue} = colour(int'(x), int'(y));

  // Expected pin word {r,g,b,hsync,vsync} for the pixel at raster position p.
  function automatic logic [13:0] pins(input int p, input bit const_col);
    int xx, yy;
    logic [11:0] col;
    logic blank, h, v;
    xx    = p % HT;
    yy    = p / HT;
    col   = const_col ? 12'hF81 : colour(xx, yy);
    blank = (xx >= HV) || (yy >= VV);
    h     = !((xx >= HV + HF) && (xx < HV + HF + HS));
    v     = !((yy >= VV + VF) && (yy < VV + VF + VS));
    return {blank ? 12'h000 : col, h, v};
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: clks and pixel ticks since reset release, updated at each edge.
  int c = 0, k = 0, k1 = 0;
  logic [13:0] q[$];
  logic [13:0] exp1 = PINS_RST;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      c = 0; k = 0; k1 = 0;
      q.delete();
      exp1 = PINS_RST;
    end else begin
      if (c % D == D - 1) begin
        q.push_back(pins(k % FR, 1'b0));
        k++;
      end
      c++;
      exp1 = pins(k1 % FR, 1'b1);
      k1++;
    end
  end

  // Monitor: samples at negedge, pops expected pins whenever the DUT ticked.
  logic        prev_rst = 1'b1;
  logic        prev_tick = 1'b0;
  logic [13:0] cur_pins = PINS_RST;
  int          fe_cnt = 0;

  initial forever begin
    logic exp_tick;
    int   pos, pos1;
    @(negedge clk);
    exp_tick = !rst && (c % D == D - 1);
    pos      = k % FR;
    chk("pix_tick", 32'(tick), 32'(exp_tick));
    chk("x", 32'(x), 32'(pos % HT));
    chk("y", 32'(y), 32'(pos / HT));
    chk("frame_end", 32'(fe), 32'(exp_tick && pos == FR - 1));

    if (prev_rst) begin
      cur_pins = PINS_RST;
      fe_cnt   = 0;
    end else if (prev_tick) begin
      if (q.size() == 0) begin
        chk("scoreboard_empty", 32'(1), 32'(0));
      end else begin
        cur_pins = q.pop_front();
      end
    end
    chk("pins", 32'({vr, vg, vb, hs, vs}), 32'(cur_pins));

    if (tick === 1'b1) fe_cnt++;
    if (fe === 1'b1) begin
      chk("frame_len", 32'(fe_cnt), 32'(FR));
      fe_cnt = 0;
    end

    pos1 = k1 % FR;
    chk("div1_tick", 32'(tick1), 32'(!rst));
    chk("div1_x", 32'(x1), 32'(pos1 % HT));
    chk("div1_y", 32'(y1), 32'(pos1 / HT));
    chk("div1_frame_end", 32'(fe1), 32'(!rst && pos1 == FR - 1));
    chk("div1_pins", 32'({vr1, vg1, vb1, hs1, vs1}), 32'(exp1));

    prev_rst  = rst;
    prev_tick = tick;
  end

  // Stimulus: long first run with red = x[3:0], then random mid-frame resets.
  initial begin
    rst = 1'b1;
    kr = 4'h0; kg = 4'h0; kb = 4'h0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3000) @(posedge clk);
    for (int s = 0; s < 7; s++) begin
      #2 rst = 1'b1;
      kr = 4'($urandom); kg = 4'($urandom); kb = 4'($urandom);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #2 rst = 1'b0;
      repeat ($urandom_range(100, 2500)) @(posedge clk);
    end
    repeat (2500) @(posedge clk);
    repeat (2) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
